// File: rtl/bdiv.sv
// Sequential restoring divider: 16.16 unsigned dividend by 8.8 unsigned
// divisor gives an 8.8 quotient and a 16-bit remainder. One quotient bit
// is produced per ITER cycle, MSB first. Divide-by-zero and quotient
// overflow are caught up front so the iterative loop is never entered
// for a result that cannot fit.
module bdiv (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a_int1,
  input  logic [7:0] a_int2,
  input  logic [7:0] a_dec1,
  input  logic [7:0] a_dec2,
  input  logic [7:0] b_int,
  input  logic [7:0] b_dec,
  input  logic       in_rdy,
  output logic [7:0] q_int,
  output logic [7:0] q_dec,
  output logic [7:0] r_hi,
  output logic [7:0] r_lo,
  output logic       res_rdy,
  output logic       busy,
  output logic       dz,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] op_hi;   // dividend integer half, seeds the partial remainder
  logic [15:0] op_lo;   // dividend fraction half, shifted out MSB first
  logic [15:0] op_d;    // divisor
  logic [16:0] pr;      // partial remainder
  logic [14:0] q_acc;   // quotient bits gathered so far
  logic [3:0]  cnt;     // iteration step 0..15
  logic [17:0] step;    // {quotient bit, next partial remainder}
  logic        err_dz;
  logic        err_ovf;

  // One restoring step: shift the next dividend bit in, subtract the
  // divisor when it fits, and report whether it did.
  function automatic logic [17:0] div_step(input logic [16:0] rem,
                                           input logic        din,
                                           input logic [15:0] dvs);
    logic [17:0] sh;
    sh = {rem, din};
    if (sh >= {2'b00, dvs})
      div_step = {1'b1, 17'(sh - {2'b00, dvs})};
    else
      div_step = {1'b0, sh[16:0]};
  endfunction

  assign step = div_step(pr, op_lo[15], op_d);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state selection and error classification of the captured operands.
  always_comb begin
    state_nxt = state;
    err_dz    = 1'b0;
    err_ovf   = 1'b0;
    case (state)
      IDLE:  if (in_rdy) state_nxt = CHECK;
      CHECK: begin
        if (op_d == 16'd0) begin
          err_dz    = 1'b1;
          state_nxt = DONE;
        end else if (op_hi >= op_d) begin
          // Quotient would need more than 16 bits.
          err_ovf   = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = ITER;
        end
      end
      ITER:  if (cnt == 4'd15) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_hi   <= '0;
      op_lo   <= '0;
      op_d    <= '0;
      pr      <= '0;
      q_acc   <= '0;
      cnt     <= '0;
      q_int   <= '0;
      q_dec   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      dz      <= 1'b0;
      ovf     <= 1'b0;
      res_rdy <= 1'b0;
      busy    <= 1'b0;
    end else begin
      res_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (in_rdy) begin
            op_hi <= {a_int1, a_int2};
            op_lo <= {a_dec1, a_dec2};
            op_d  <= {b_int, b_dec};
            busy  <= 1'b1;
          end
        end
        CHECK: begin
          pr    <= {1'b0, op_hi};
          q_acc <= '0;
          cnt   <= '0;
          if (err_dz || err_ovf) begin
            {q_int, q_dec} <= 16'hFFFF;
            {r_hi, r_lo}   <= 16'h0000;
            dz             <= err_dz;
            ovf            <= err_ovf;
            res_rdy        <= 1'b1;
          end
        end
        ITER: begin
          pr    <= step[16:0];
          q_acc <= {q_acc[13:0], step[17]};
          op_lo <= {op_lo[14:0], 1'b0};
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            // Remainder is always below the divisor, so 16 bits suffice.
            {q_int, q_dec} <= {q_acc, step[17]};
            {r_hi, r_lo}   <= step[15:0];
            dz             <= 1'b0;
            ovf            <= 1'b0;
            res_rdy        <= 1'b1;
          end
        end
        DONE: busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bdiv.sv
// Bench for bdiv: a transaction-level model (integer division plus the
// fixed latencies) is checked against the DUT on every cycle, alongside
// hand-computed directed cases, random traffic and reset/back-to-back runs.
module tb_bdiv;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_int1, a_int2, a_dec1, a_dec2, b_int, b_dec;
  logic       in_rdy;
  logic [7:0] q_int, q_dec, r_hi, r_lo;
  logic       res_rdy, busy, dz, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  bdiv dut (
    .clk(clk), .rst(rst),
    .a_int1(a_int1), .a_int2(a_int2), .a_dec1(a_dec1), .a_dec2(a_dec2),
    .b_int(b_int), .b_dec(b_dec), .in_rdy(in_rdy),
    .q_int(q_int), .q_dec(q_dec), .r_hi(r_hi), .r_lo(r_lo),
    .res_rdy(res_rdy), .busy(busy), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ovf;
  } res_t;

  // Reference result from plain integer arithmetic.
  function automatic res_t ref_div(input logic [31:0] dd, input logic [15:0] dv);
    res_t x;
    if (dv == 16'd0) begin
      x.q = 16'hFFFF; x.r = 16'h0; x.dz = 1'b1; x.ovf = 1'b0;
    end else if ((dd / {16'h0, dv}) > 32'h0000_FFFF) begin
      x.q = 16'hFFFF; x.r = 16'h0; x.dz = 1'b0; x.ovf = 1'b1;
    end else begin
      x.q = 16'(dd / {16'h0, dv});
      x.r = 16'(dd % {16'h0, dv});
      x.dz = 1'b0; x.ovf = 1'b0;
    end
    return x;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Transaction model: edge counter, one job in flight, current result.
  int   cyc = 0;
  bit   active = 1'b0;
  int   due = 0;
  res_t pend = '0;
  res_t cur = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      active = 1'b0;
      cur    = '0;
    end else begin
      if (!active && in_rdy) begin
        pend   = ref_div({a_int1, a_int2, a_dec1, a_dec2}, {b_int, b_dec});
        active = 1'b1;
        due    = cyc + ((pend.dz || pend.ovf) ? 1 : 17);
      end else if (active && cyc == due + 1) begin
        active = 1'b0;
      end
      if (active && cyc == due) cur = pend;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (rst)
      check("reset_outputs", {28'h0, q_int, q_dec, r_hi, r_lo, dz, ovf, res_rdy, busy}, 64'h0);
    else
      check("cycle_outputs", {28'h0, q_int, q_dec, r_hi, r_lo, dz, ovf, res_rdy, busy},
            {28'h0, cur.q, cur.r, cur.dz, cur.ovf, (active && cyc == due), active});
  end

  task automatic wait_idle();
    int k = 0;
    while ((busy || active) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", {63'h0, busy}, 64'h0);
  endtask

  task automatic drive(input logic [31:0] dd, input logic [15:0] dv, output int t0);
    @(posedge clk);
    #2;
    {a_int1, a_int2, a_dec1, a_dec2} = dd;
    {b_int, b_dec} = dv;
    in_rdy = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    #1 in_rdy = 1'b0;
    {a_int1, a_int2, a_dec1, a_dec2} = $urandom;
    {b_int, b_dec} = 16'($urandom);
  endtask

  task automatic run(input string nm, input logic [31:0] dd, input logic [15:0] dv,
                     input int lat, input logic [15:0] q, input logic [15:0] r,
                     input logic ez, input logic eo);
    int t0;
    int k;
    wait_idle();
    drive(dd, dv, t0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!res_rdy && k < 40);
    check({nm, "_latency"}, 64'(cyc - t0), 64'(lat));
    check({nm, "_value"}, {30'h0, q_int, q_dec, r_hi, r_lo, dz, ovf}, {30'h0, q, r, ez, eo});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int        t0;
    int        pulses;
    int        stamps[$];
    logic [15:0] a, b, hi;
    logic [31:0] dd;
    res_t      e;

    rst = 1'b1;
    in_rdy = 1'b0;
    {a_int1, a_int2, a_dec1, a_dec2, b_int, b_dec} = '0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", {28'h0, q_int, q_dec, r_hi, r_lo, dz, ovf, res_rdy, busy}, 64'h0);
    #1 rst = 1'b0;

    // Directed, hand-computed cases.
    run("exact",     32'h0003_0000, 16'h0200, 17, 16'h0180, 16'h0000, 1'b0, 1'b0);
    run("product",   32'h0003_C000, 16'h0180, 17, 16'h0280, 16'h0000, 1'b0, 1'b0);
    run("inexact",   32'h0001_0000, 16'h0300, 17, 16'h0055, 16'h0100, 1'b0, 1'b0);
    run("div_zero",  32'h1234_5678, 16'h0000,  1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run("overflow",  32'h0200_0000, 16'h0100,  1, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    run("boundary",  32'h00FF_FFFF, 16'h0100, 17, 16'hFFFF, 16'h00FF, 1'b0, 1'b0);
    run("ovf_edge",  32'h0100_0000, 16'h0100,  1, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    run("max_div",   32'hFFFE_FFFF, 16'hFFFF, 17, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0);

    // Products divide back exactly.
    for (int i = 0; i < 10; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom_range(1, 65535));
      dd = {16'h0, a} * {16'h0, b};
      run("inverse", dd, b, 17, a, 16'h0000, 1'b0, 1'b0);
    end

    // Random traffic, including zero divisors and overflowing dividends.
    for (int i = 0; i < 30; i++) begin
      b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
      if ($urandom_range(0, 2) == 0 || b == 16'h0)
        dd = $urandom;
      else
        dd = {16'($urandom % {16'h0, b}), 16'($urandom)};
      e = ref_div(dd, b);
      run("random", dd, b, (e.dz || e.ovf) ? 1 : 17, e.q, e.r, e.dz, e.ovf);
    end

    // Reset in the middle of an iteration aborts it cleanly.
    wait_idle();
    drive(32'h0003_0000, 16'h0200, t0);
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("reset_midop", {28'h0, q_int, q_dec, r_hi, r_lo, dz, ovf, res_rdy, busy}, 64'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_rdy) pulses++;
    end
    check("abort_no_result", 64'(pulses), 64'h0);
    run("after_reset", 32'h0003_0000, 16'h0200, 17, 16'h0180, 16'h0000, 1'b0, 1'b0);

    // in_rdy held high with operands changing every cycle.
    wait_idle();
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #2;
      b = 16'($urandom_range(1, 65535));
      hi = 16'($urandom % {16'h0, b});
      {a_int1, a_int2} = hi;
      {a_dec1, a_dec2} = 16'($urandom);
      {b_int, b_dec} = b;
      in_rdy = 1'b1;
      @(negedge clk);
      if (res_rdy) stamps.push_back(cyc);
    end
    in_rdy = 1'b0;
    check("held_pulse_count", 64'(stamps.size() >= 5), 64'h1);
    for (int i = 1; i < stamps.size(); i++)
      check("held_period", 64'(stamps[i] - stamps[i-1]), 64'd19);

    wait_idle();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bdiv.md
BDIV -- requirements
Module: bdiv

Interface
REQ-001 SHALL have no parameters; all widths fixed: dividend 16.16 unsigned, divisor 8.8 unsigned, quotient 8.8 unsigned.
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
  clk  in  1  clock, all state updated on rising edge
  rst  in  1  reset, asynchronous, active-high
  a_int1  in  8  dividend bits 31:24
  a_int2  in  8  dividend bits 23:16
  a_dec1  in  8  dividend bits 15:8
  a_dec2  in  8  dividend bits 7:0
  b_int  in  8  divisor bits 15:8
  b_dec  in  8  divisor bits 7:0
  in_rdy  in  1  operands valid; sampled only in IDLE
  q_int  out  8  quotient integer byte (bits 15:8)
  q_dec  out  8  quotient fraction byte (bits 7:0)
  r_hi  out  8  remainder bits 15:8
  r_lo  out  8  remainder bits 7:0
  res_rdy  out  1  one-cycle result strobe
  busy  out  1  high from capture until return to IDLE
  dz  out  1  divide-by-zero flag for current result
  ovf  out  1  quotient-overflow flag for current result

Function
REQ-003 SHALL compute Q = floor(D / d), R = D - Q*d, where D = {a_int1,a_int2,a_dec1,a_dec2} (32 b) and d = {b_int,b_dec} (16 b); Q is the 8.8 value of (D/2^16)/(d/2^8).
REQ-004 SHALL implement restoring radix-2 division, one quotient bit per cycle, MSB first; partial remainder 17 b wide, initialised to D[31:16]; per step: shift in next dividend bit, subtract d if partial remainder >= d, set quotient bit accordingly.
REQ-005 SHALL use FSM states IDLE, CHECK, ITER, DONE; transitions: IDLE->CHECK on in_rdy=1; CHECK->ITER (normal) or CHECK->DONE (error); ITER->ITER for steps 0..14, ITER->DONE after step 15; DONE->IDLE unconditionally.
REQ-006 SHALL, at the edge IDLE samples in_rdy=1 (edge N), capture all six operand bytes into internal registers and set busy=1; operand inputs are don't-care afterwards.
REQ-007 SHALL ignore in_rdy in CHECK, ITER and DONE; no queuing of requests.
REQ-008 SHALL, in CHECK, detect d==0 first (dz=1, ovf=0), else D[31:16] >= d (ovf=1, dz=0); on either: Q=0xFFFF, R=0x0000, go to DONE.
REQ-009 SHALL, normal case, load outputs and assert res_rdy at edge N+17 (16 ITER cycles); error case at edge N+1.
REQ-010 SHALL hold res_rdy high exactly one cycle (DONE); at the following edge res_rdy=0, busy=0, state IDLE; earliest next capture at that IDLE cycle's edge.
REQ-011 SHALL hold q_int, q_dec, r_hi, r_lo, dz, ovf stable from res_rdy assertion until the next result is loaded; not updated during ITER.
REQ-012 SHALL clear dz and ovf on every normal completion.
REQ-013 SHALL guarantee R < d for every normal result; quotient never truncated (overflow caught by REQ-008).

Reset
REQ-014 SHALL, on rst=1 at any time including mid-ITER, asynchronously force state=IDLE, iteration counter=0, busy=0, res_rdy=0, dz=0, ovf=0, q_int=q_dec=r_hi=r_lo=0x00, internal operand/partial registers=0.
REQ-015 SHALL not assert res_rdy for an operation aborted by reset; first capture possible at the first clk edge with rst=0 and in_rdy=1.

Verification
REQ-016 Exact: D=0x0003_0000, d=0x0200, in_rdy pulse -> res_rdy at edge N+17, Q=0x0180, R=0x0000, dz=ovf=0.
REQ-017 Product inverse: D=0x0003_C000 (2.5*1.5), d=0x0180 -> Q=0x0280, R=0x0000; sweep random 8.8 pairs a,b with D=a*b, d=b!=0 -> Q=a, R=0.
REQ-018 Inexact: D=0x0001_0000, d=0x0300 -> Q=0x0055, R=0x0100.
REQ-019 Errors: d=0x0000 -> res_rdy at edge N+1, dz=1, ovf=0, Q=0xFFFF, R=0; D=0x0200_0000, d=0x0100 -> ovf=1, dz=0, Q=0xFFFF; boundary D=0x00FF_FFFF, d=0x0100 -> ovf=0, Q=0xFFFF, R=0x00FF.
REQ-020 Reset mid-op: start D=0x0003_0000, d=0x0200, assert rst at edge N+8 -> all outputs 0 immediately, no res_rdy; new request after release completes normally in 17 edges.
REQ-021 Busy/ignore: in_rdy held high continuously with changing operands -> only operands sampled in IDLE used; res_rdy pulses every 19 cycles, each one cycle wide.
